// File: rtl/acq_controller.sv
`default_nettype none
//============================================================================
// Module   : acq_controller
// Brief    : Scope time-base acquisition sequencer. Gates and configures the
//            ADC clock divider, turns ADC clock rises into clk50 sample
//            strobes, fills a circular sample RAM with a pre-trigger window,
//            detects a level (or forced) trigger and captures the
//            post-trigger window before flagging done.
// Revision : 1.0 - initial release
//============================================================================
module acq_controller #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 10,
    parameter int PRE_TRIG = 256
) (
    input  logic              clk50,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic              force_trig,
    input  logic [2:0]        base_sel,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic              adc_clk,
    input  logic [DATA_W-1:0] adc_data,
    output logic              div_enable,
    output logic              div_rst,
    output logic [2:0]        div_base,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Last pre-trigger write index and number of writes after the trigger sample.
    localparam logic [ADDR_W-1:0] c_PRE_LAST = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] c_POST_CNT = ADDR_W'(DEPTH - PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] c_ONE      = ADDR_W'(1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_CONFIG   = 3'd1;
    localparam logic [2:0] c_PRETRIG  = 3'd2;
    localparam logic [2:0] c_ARMED    = 3'd3;
    localparam logic [2:0] c_POSTTRIG = 3'd4;
    localparam logic [2:0] c_DONE     = 3'd5;

    logic [2:0]        r_state;
    logic              r_cfg_cnt;
    logic [2:0]        r_adc_sync;
    logic              r_wr_en;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_force;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_prev;
    logic              r_have_prev;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [2:0]        r_div_base;

    logic              w_stb;
    logic              w_sampling;
    logic              w_capture;
    logic              w_rise_hit;
    logic              w_fall_hit;
    logic              w_level_hit;
    logic              w_trig;

    // Two synchroniser flops followed by one edge-detect flop on adc_clk.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            r_adc_sync <= '0;
        end else begin
            r_adc_sync <= {r_adc_sync[1:0], adc_clk};
        end
    end

    assign w_stb      = r_adc_sync[1] & ~r_adc_sync[2];

    // Strobes are only turned into writes while a capture window is open;
    // CONFIG, IDLE and DONE drop them, and abort kills a strobe in flight.
    assign w_sampling = (r_state == c_PRETRIG) || (r_state == c_ARMED) ||
                        (r_state == c_POSTTRIG);
    assign w_capture  = w_stb && w_sampling && !abort;

    // Register the sample (and the force request seen at its strobe); the
    // RAM write happens on the following cycle.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_force   <= 1'b0;
        end else begin
            r_wr_en <= w_capture;
            if (w_capture) begin
                r_wr_data <= adc_data;
                r_force   <= force_trig;
            end
        end
    end

    // Level crossing between the previously written sample and the one being
    // written now. No previous sample means no level trigger is possible.
    assign w_rise_hit  = (r_prev < trig_level) && (r_wr_data >= trig_level);
    assign w_fall_hit  = (r_prev > trig_level) && (r_wr_data <= trig_level);
    assign w_level_hit = r_have_prev && (trig_rising ? w_rise_hit : w_fall_hit);
    assign w_trig      = r_wr_en && (r_force || w_level_hit);

    // Sequencer: arm/config/pre-trigger/armed/post-trigger/done, plus the
    // write pointer and previous-sample tracking that advance on each write.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cfg_cnt   <= 1'b0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_trig_addr <= '0;
            r_div_base  <= '0;
        end else if (abort) begin
            r_state   <= c_IDLE;
            r_cfg_cnt <= 1'b0;
        end else begin
            if (r_wr_en) begin
                r_ptr       <= r_ptr + c_ONE;
                r_prev      <= r_wr_data;
                r_have_prev <= 1'b1;
            end

            case (r_state)
                c_IDLE, c_DONE: begin
                    if (arm) begin
                        r_div_base  <= base_sel;
                        r_ptr       <= '0;
                        r_cnt       <= '0;
                        r_have_prev <= 1'b0;
                        r_trig_addr <= '0;
                        r_cfg_cnt   <= 1'b0;
                        r_state     <= c_CONFIG;
                    end
                end

                // Two cycles of divider reset, then start sampling.
                c_CONFIG: begin
                    if (r_cfg_cnt) begin
                        r_cfg_cnt <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= (PRE_TRIG == 0) ? c_ARMED : c_PRETRIG;
                    end else begin
                        r_cfg_cnt <= 1'b1;
                    end
                end

                c_PRETRIG: begin
                    if (r_wr_en) begin
                        if (r_cnt == c_PRE_LAST) begin
                            r_cnt   <= '0;
                            r_state <= c_ARMED;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end

                c_ARMED: begin
                    if (w_trig) begin
                        r_trig_addr <= r_ptr;
                        if (c_POST_CNT == '0) begin
                            r_state <= c_DONE;
                        end else begin
                            r_cnt   <= c_POST_CNT;
                            r_state <= c_POSTTRIG;
                        end
                    end
                end

                // r_cnt holds the number of post-trigger writes still owed.
                c_POSTTRIG: begin
                    if (r_wr_en) begin
                        if (r_cnt == c_ONE) begin
                            r_state <= c_DONE;
                        end else begin
                            r_cnt <= r_cnt - c_ONE;
                        end
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Output decode: every output is a register or a state decode, so reset
    // drives all of them to zero immediately.
    assign div_rst    = (r_state == c_CONFIG);
    assign div_enable = (r_state == c_CONFIG) || w_sampling;
    assign busy       = div_enable;
    assign done       = (r_state == c_DONE);
    assign div_base   = r_div_base;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_ptr;
    assign wr_data    = r_wr_data;
    assign trig_addr  = r_trig_addr;

endmodule
`default_nettype wire

// File: tb/tb_acq_controller.sv
`default_nettype none
//============================================================================
// Module   : tb_acq_controller
// Brief    : Self-checking bench for acq_controller (ADDR_W=4, PRE_TRIG=4).
//            A divider model produces adc_clk from div_enable/div_rst/div_base
//            and plays a sample sequence; captures are checked against
//            hand-derived table entries and a sample-list trigger model.
// Revision : 1.0 - initial release
//============================================================================
module tb_acq_controller;

    localparam int DW      = 8;
    localparam int AW      = 4;
    localparam int PRE     = 4;
    localparam int DEPTH   = 16;
    localparam int POST    = DEPTH - PRE - 1;
    localparam int NOFORCE = 1000;
    localparam int SEQ_N   = 256;

    logic          clk50 = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          force_trig = 1'b0;
    logic [2:0]    base_sel = 3'd0;
    logic [DW-1:0] trig_level = '0;
    logic          trig_rising = 1'b1;
    logic          adc_clk = 1'b1;
    logic [DW-1:0] adc_data = '0;
    logic          div_enable;
    logic          div_rst;
    logic [2:0]    div_base;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] trig_addr;
    logic          busy;
    logic          done;

    acq_controller #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .PRE_TRIG(PRE)
    ) dut (
        .clk50      (clk50),
        .rst        (rst),
        .arm        (arm),
        .abort      (abort),
        .force_trig (force_trig),
        .base_sel   (base_sel),
        .trig_level (trig_level),
        .trig_rising(trig_rising),
        .adc_clk    (adc_clk),
        .adc_data   (adc_data),
        .div_enable (div_enable),
        .div_rst    (div_rst),
        .div_base   (div_base),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .trig_addr  (trig_addr),
        .busy       (busy),
        .done       (done)
    );

    always #10 clk50 = ~clk50;

    int checks = 0;
    int errors = 0;
    int g_nwr  = 0;
    int g_since = 0;
    int g_nrst = 0;

    logic [DW-1:0] seq [0:SEQ_N-1];

    // Divider model: parked high when disabled or in reset, otherwise a
    // square wave of half period 4+div_base clk50 cycles. Sample k of seq is
    // presented on the falling edge ahead of the k-th rise.
    int half_cnt = 0;
    int sidx = 0;
    always @(negedge clk50) begin
        if (!div_enable || div_rst) begin
            adc_clk  = 1'b1;
            half_cnt = 0;
            sidx     = 0;
        end else if (half_cnt >= 3 + int'(div_base)) begin
            half_cnt = 0;
            if (adc_clk) begin
                adc_data = seq[sidx];
                if (sidx < SEQ_N - 1) sidx = sidx + 1;
            end
            adc_clk = ~adc_clk;
        end else begin
            half_cnt = half_cnt + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    // One clk50 cycle; every RAM write must land at the next circular
    // address with the next sample of the sequence.
    task automatic tick();
        @(negedge clk50);
        if (div_rst) g_nrst++;
        if (wr_en) begin
            chk("wr_addr", int'(wr_addr), g_nwr % DEPTH);
            if (g_nwr < SEQ_N) chk("wr_data", int'(wr_data), int'(seq[g_nwr]));
            g_nwr++;
            g_since = 0;
        end else begin
            g_since++;
        end
    endtask

    // Run until the write count reaches target (or done, if want_done),
    // raising force_trig once fidx writes have been seen.
    task automatic run_until(input int target, input bit want_done, input int fidx);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (fidx != NOFORCE && g_nwr >= fidx) force_trig = 1'b1;
            if (want_done ? (done == 1'b1) : (g_nwr >= target)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout: writes %0d done %0d required writes %0d done %0d",
                     g_nwr, done, target, want_done);
        end
    endtask

    task automatic do_arm(input logic [2:0] base);
        g_nwr   = 0;
        g_since = 0;
        g_nrst  = 0;
        base_sel = base;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        base_sel = ~base;
        chk("div_base_latched", int'(div_base), int'(base));
        chk("busy_after_arm", int'(busy), 1);
        chk("done_cleared", int'(done), 0);
    endtask

    task automatic run_capture(input logic [2:0] base, input logic [DW-1:0] lvl,
                               input logic rise, input int fidx,
                               input int exp_taddr, input int exp_writes);
        trig_level  = lvl;
        trig_rising = rise;
        force_trig  = 1'b0;
        do_arm(base);
        run_until(0, 1'b1, fidx);
        force_trig = 1'b0;
        chk("div_rst_cycles", g_nrst, 2);
        chk("write_count", g_nwr, exp_writes);
        chk("done_latency", g_since, 1);
        chk("trig_addr", int'(trig_addr), exp_taddr);
        chk("busy_at_done", int'(busy), 0);
        chk("div_enable_at_done", int'(div_enable), 0);
        repeat (30) tick();
        chk("no_writes_after_done", g_nwr, exp_writes);
        chk("done_held", int'(done), 1);
        chk("trig_addr_held", int'(trig_addr), exp_taddr);
    endtask

    function automatic void fill_ramp(input bit down);
        for (int i = 0; i < SEQ_N; i++) seq[i] = down ? DW'(200 - i) : DW'(i);
    endfunction

    // Index of the triggering sample: first armed sample (index >= PRE) that
    // sees force or crosses the level relative to the sample before it.
    function automatic int model_trig(input int lvl, input bit rise, input int fidx);
        for (int i = PRE; i < SEQ_N; i++) begin
            if (i >= fidx) return i;
            if (i > 0) begin
                if (rise && int'(seq[i-1]) < lvl && int'(seq[i]) >= lvl) return i;
                if (!rise && int'(seq[i-1]) > lvl && int'(seq[i]) <= lvl) return i;
            end
        end
        return -1;
    endfunction

    typedef struct {
        bit down;
        int base;
        int lvl;
        bit rise;
        int fidx;
        int exp_taddr;
        int exp_writes;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int n0;
        int t;
        int lvl;
        int fidx;
        bit rise;
        logic [2:0] base;

        vecs[0] = '{1'b0, 0, 10,  1'b1, NOFORCE, 10, 22};
        vecs[1] = '{1'b1, 2, 150, 1'b0, NOFORCE, 2,  62};
        vecs[2] = '{1'b0, 5, 255, 1'b1, 40,      8,  52};
        vecs[3] = '{1'b0, 1, 3,   1'b1, 9,       9,  21};
        vecs[4] = '{1'b0, 3, 4,   1'b1, NOFORCE, 4,  16};
        vecs[5] = '{1'b0, 7, 100, 1'b0, 6,       6,  18};
        vecs[6] = '{1'b1, 0, 196, 1'b0, NOFORCE, 4,  16};
        fill_ramp(1'b0);

        // Reset state
        #5;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_div_enable", int'(div_enable), 0);
        chk("rst_div_rst", int'(div_rst), 0);
        chk("rst_div_base", int'(div_base), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_trig_addr", int'(trig_addr), 0);
        repeat (3) @(negedge clk50);
        rst = 1'b0;
        repeat (5) tick();

        // Table-driven captures
        for (int v = 0; v < 7; v++) begin
            fill_ramp(vecs[v].down);
            run_capture(3'(vecs[v].base), DW'(vecs[v].lvl), vecs[v].rise,
                        vecs[v].fidx, vecs[v].exp_taddr, vecs[v].exp_writes);
        end

        // Random sample streams against the trigger model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < SEQ_N; i++) seq[i] = DW'($urandom_range(0, 255));
            lvl  = int'($urandom_range(0, 255));
            rise = 1'($urandom_range(0, 1));
            fidx = int'($urandom_range(4, 40));
            base = 3'($urandom_range(0, 7));
            t = model_trig(lvl, rise, fidx);
            run_capture(base, DW'(lvl), rise, fidx, t % DEPTH, t + 1 + POST);
        end

        // Reset asserted mid-capture: outputs drop in the same cycle
        fill_ramp(1'b0);
        trig_level = 8'd255;
        trig_rising = 1'b1;
        do_arm(3'd1);
        run_until(6, 1'b0, NOFORCE);
        #3 rst = 1'b1;
        #1;
        chk("midrst_wr_en", int'(wr_en), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_div_enable", int'(div_enable), 0);
        chk("midrst_wr_addr", int'(wr_addr), 0);
        chk("midrst_div_base", int'(div_base), 0);
        chk("midrst_wr_data", int'(wr_data), 0);
        n0 = g_nwr;
        repeat (4) tick();
        rst = 1'b0;
        repeat (40) tick();
        chk("midrst_no_writes", g_nwr, n0);
        chk("midrst_idle", int'(busy), 0);

        // Abort during the post-trigger window
        fill_ramp(1'b0);
        trig_level = 8'd10;
        do_arm(3'd2);
        run_until(14, 1'b0, NOFORCE);
        n0 = g_nwr;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_div_enable", int'(div_enable), 0);
        chk("abort_div_rst", int'(div_rst), 0);
        repeat (80) tick();
        chk("abort_no_writes", g_nwr, n0);

        // Arm while armed is ignored; then force, then arm+abort from DONE
        trig_level = 8'd255;
        do_arm(3'd3);
        run_until(8, 1'b0, NOFORCE);
        base_sel = 3'd6;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("rearm_div_base", int'(div_base), 3);
        chk("rearm_busy", int'(busy), 1);
        chk("rearm_div_rst", int'(div_rst), 0);
        n0 = g_nwr;
        run_until(0, 1'b1, n0);
        force_trig = 1'b0;
        chk("rearm_trig_addr", int'(trig_addr), n0 % DEPTH);
        chk("rearm_write_count", g_nwr, n0 + 1 + POST);
        base_sel = 3'd5;
        arm = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        chk("armabort_busy", int'(busy), 0);
        chk("armabort_done", int'(done), 0);
        chk("armabort_div_enable", int'(div_enable), 0);
        chk("armabort_div_rst", int'(div_rst), 0);
        chk("armabort_div_base", int'(div_base), 3);
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
